// File: rtl/sprite_pkg.sv
// Shared constants, widths and FSM encoding for the sprite drawing blocks.
package sprite_pkg;
    localparam int SCREEN_W = 160;
    localparam int SCREEN_H = 120;
    localparam int COLOUR_W = 3;
    localparam int X_W      = 8;
    localparam int Y_W      = 7;
    localparam logic [COLOUR_W-1:0] TRANSPARENT = '0;

    typedef enum logic [1:0] {IDLE, DRAW, FLUSH, DONE} state_e;

    function automatic int cnt_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction
endpackage

// File: rtl/sprite_scan.sv
// Raster-order col/row counter with a running linear address, clear and last flag.
module sprite_scan
    import sprite_pkg::*;
#(
    parameter int SPRITE_W = 5,
    parameter int SPRITE_H = 5,
    parameter int ADDR_W   = 5,
    localparam int COL_W   = cnt_w(SPRITE_W),
    localparam int ROW_W   = cnt_w(SPRITE_H)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clr,
    input  logic              en,
    output logic [COL_W-1:0]  col,
    output logic [ROW_W-1:0]  row,
    output logic [ADDR_W-1:0] addr,
    output logic              last
);
    logic [COL_W-1:0]  col_q, col_d;
    logic [ROW_W-1:0]  row_q, row_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              col_end;

    assign col_end = (col_q == COL_W'(SPRITE_W - 1));
    assign last    = col_end && (row_q == ROW_W'(SPRITE_H - 1));

    // The address is tracked incrementally so no multiplier is needed.
    always_comb begin
        col_d  = col_q;
        row_d  = row_q;
        addr_d = addr_q;
        if (clr || (en && last)) begin
            col_d  = '0;
            row_d  = '0;
            addr_d = '0;
        end else if (en) begin
            addr_d = addr_q + 1'b1;
            if (col_end) begin
                col_d = '0;
                row_d = row_q + 1'b1;
            end else begin
                col_d = col_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            col_q  <= '0;
            row_q  <= '0;
            addr_q <= '0;
        end else begin
            col_q  <= col_d;
            row_q  <= row_d;
            addr_q <= addr_d;
        end
    end

    assign col  = col_q;
    assign row  = row_q;
    assign addr = addr_q;
endmodule

// File: rtl/sprite_plotter.sv
// Draws one sprite from a synchronous ROM into the VGA framebuffer write port,
// clipping pixels that fall off the right or bottom of the screen.
module sprite_plotter
    import sprite_pkg::*;
#(
    parameter int SPRITE_W = 5,
    parameter int SPRITE_H = 5,
    parameter int ADDR_W   = 5,
    parameter int COLOUR_W = sprite_pkg::COLOUR_W,
    parameter int SCREEN_W = sprite_pkg::SCREEN_W,
    parameter int SCREEN_H = sprite_pkg::SCREEN_H,
    parameter logic [COLOUR_W-1:0] TRANSPARENT = sprite_pkg::TRANSPARENT
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic [X_W-1:0]      origin_x,
    input  logic [Y_W-1:0]      origin_y,
    output logic                busy,
    output logic                done,
    output logic [ADDR_W-1:0]   rom_address,
    input  logic [COLOUR_W-1:0] rom_data,
    output logic                plot,
    output logic [X_W-1:0]      x,
    output logic [Y_W-1:0]      y,
    output logic [COLOUR_W-1:0] colour
);
    localparam int COL_W = cnt_w(SPRITE_W);
    localparam int ROW_W = cnt_w(SPRITE_H);

    state_e             state_q, state_d;
    logic               busy_q, busy_d, done_q, done_d, flush_q, flush_d;
    logic [X_W-1:0]     origin_x_q, origin_x_d;
    logic [Y_W-1:0]     origin_y_q, origin_y_d;
    logic               scan_clr, scan_en, scan_last;
    logic [COL_W-1:0]   scan_col, col_dly_q;
    logic [ROW_W-1:0]   scan_row, row_dly_q;
    logic               vld_dly_q;
    logic [X_W:0]       x_sum;
    logic [Y_W:0]       y_sum;
    logic               plot_q, plot_d;
    logic [X_W-1:0]     x_q, x_d;
    logic [Y_W-1:0]     y_q, y_d;
    logic [COLOUR_W-1:0] colour_q, colour_d;

    sprite_scan #(.SPRITE_W(SPRITE_W), .SPRITE_H(SPRITE_H), .ADDR_W(ADDR_W)) u_scan (
        .clk  (clk),
        .reset(reset),
        .clr  (scan_clr),
        .en   (scan_en),
        .col  (scan_col),
        .row  (scan_row),
        .addr (rom_address),
        .last (scan_last)
    );

    always_comb begin
        state_d    = state_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        flush_d    = flush_q;
        origin_x_d = origin_x_q;
        origin_y_d = origin_y_q;
        scan_clr   = 1'b0;
        scan_en    = 1'b0;
        case (state_q)
            IDLE: if (start) begin
                state_d    = DRAW;
                busy_d     = 1'b1;
                origin_x_d = origin_x;
                origin_y_d = origin_y;
                scan_clr   = 1'b1;
            end
            DRAW: begin
                scan_en = 1'b1;
                if (scan_last) begin
                    state_d = FLUSH;
                    flush_d = 1'b0;
                end
            end
            FLUSH: begin
                flush_d = 1'b1;
                if (flush_q) begin
                    state_d = DONE;
                    done_d  = 1'b1;
                end
            end
            DONE: begin
                busy_d  = 1'b0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Sums are one bit wider so an off-screen pixel can never wrap back on.
    always_comb begin
        x_sum    = {1'b0, origin_x_q} + (X_W+1)'(col_dly_q);
        y_sum    = {1'b0, origin_y_q} + (Y_W+1)'(row_dly_q);
        plot_d   = vld_dly_q && (rom_data != TRANSPARENT)
                   && (x_sum < (X_W+1)'(SCREEN_W)) && (y_sum < (Y_W+1)'(SCREEN_H));
        x_d      = plot_d ? x_sum[X_W-1:0] : x_q;
        y_d      = plot_d ? y_sum[Y_W-1:0] : y_q;
        colour_d = plot_d ? rom_data : colour_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            flush_q    <= 1'b0;
            origin_x_q <= '0;
            origin_y_q <= '0;
            col_dly_q  <= '0;
            row_dly_q  <= '0;
            vld_dly_q  <= 1'b0;
            plot_q     <= 1'b0;
            x_q        <= '0;
            y_q        <= '0;
            colour_q   <= '0;
        end else begin
            state_q    <= state_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            flush_q    <= flush_d;
            origin_x_q <= origin_x_d;
            origin_y_q <= origin_y_d;
            col_dly_q  <= scan_col;
            row_dly_q  <= scan_row;
            vld_dly_q  <= (state_q == DRAW);
            plot_q     <= plot_d;
            x_q        <= x_d;
            y_q        <= y_d;
            colour_q   <= colour_d;
        end
    end

    assign busy   = busy_q;
    assign done   = done_q;
    assign plot   = plot_q;
    assign x      = x_q;
    assign y      = y_q;
    assign colour = colour_q;
endmodule

// File: tb/tb_sprite_plotter.sv
// Table-driven and randomized bench for sprite_plotter with a cycle-level pixel model.
module tb_sprite_plotter;
    localparam int SW = 5;
    localparam int SH = 5;

    logic       clk = 1'b0;
    logic       reset, start;
    logic [7:0] origin_x;
    logic [6:0] origin_y;
    logic       busy, done, plot;
    logic [4:0] rom_address;
    logic [2:0] rom_data;
    logic [7:0] x;
    logic [6:0] y;
    logic [2:0] colour;

    int checks = 0;
    int errors = 0;
    int rom_mode = 0;
    int rom_tbl[32];

    typedef struct {
        int ox;
        int oy;
        int mode;      // 0: a%8, 1: const 5, 2: all transparent, 3: (a%7)+1, 4: random
        bit pulse5;    // extra start pulse in cycle 5
        bit pulse28;   // extra start pulse in the done cycle
        int exp_plots; // -1: count not fixed
    } vec_t;

    vec_t tbl[10];

    sprite_plotter dut (
        .clk(clk), .reset(reset), .start(start),
        .origin_x(origin_x), .origin_y(origin_y),
        .busy(busy), .done(done), .rom_address(rom_address), .rom_data(rom_data),
        .plot(plot), .x(x), .y(y), .colour(colour)
    );

    always #5 clk = ~clk;

    function automatic int rom_val(input int mode, input int a);
        case (mode)
            0: return a % 8;
            1: return 5;
            2: return 0;
            3: return (a % 7) + 1;
            default: return rom_tbl[a];
        endcase
    endfunction

    always @(posedge clk) rom_data <= 3'(rom_val(rom_mode, int'(rom_address)));

    task automatic chk(input string nm, input int k, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s cycle=%0d actual=%0d expected=%0d", nm, k, act, exp);
        end
    endtask

    // Cycle 0 is the cycle with start high; every pixel i is expected in cycle i+3.
    task automatic run_draw(input vec_t v, output int nplots);
        int xs, ys, c, i;
        bit ep;
        @(negedge clk);
        rom_mode = v.mode;
        if (v.mode == 4)
            for (int a = 0; a < 32; a++) rom_tbl[a] = $urandom_range(0, 7);
        origin_x = 8'(v.ox);
        origin_y = 7'(v.oy);
        start = 1'b1;
        chk("idle_busy", 0, int'(busy), 0);
        chk("idle_plot", 0, int'(plot), 0);
        nplots = 0;
        for (int k = 1; k <= 28; k++) begin
            @(negedge clk);
            start = v.pulse5 && (k == 5);
            origin_x = 8'($urandom);
            origin_y = 7'($urandom);
            chk("busy", k, int'(busy), 1);
            chk("done", k, int'(done), (k == 28) ? 1 : 0);
            if (k <= SW * SH) chk("rom_address", k, int'(rom_address), k - 1);
            ep = 1'b0;
            if (k >= 3 && k < 3 + SW * SH) begin
                i  = k - 3;
                xs = v.ox + i % SW;
                ys = v.oy + i / SW;
                c  = rom_val(v.mode, i);
                ep = (c != 0) && (xs < 160) && (ys < 120);
            end
            chk("plot", k, int'(plot), int'(ep));
            if (ep) begin
                chk("x", k, int'(x), xs);
                chk("y", k, int'(y), ys);
                chk("colour", k, int'(colour), c);
            end
            if (plot === 1'b1) nplots++;
            if (k == 28 && v.pulse28) start = 1'b1;
        end
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    initial begin
        int n;
        vec_t vr;
        tbl[0] = '{10, 20, 0, 1'b0, 1'b0, 21};
        tbl[1] = '{157, 118, 1, 1'b0, 1'b0, 6};
        tbl[2] = '{30, 40, 1, 1'b1, 1'b1, 25};
        tbl[3] = '{70, 10, 0, 1'b0, 1'b0, 21};
        tbl[4] = '{0, 0, 2, 1'b0, 1'b0, 0};
        tbl[5] = '{0, 0, 3, 1'b0, 1'b0, 25};
        tbl[6] = '{50, 60, 3, 1'b0, 1'b0, 25};
        for (int j = 7; j < 10; j++)
            tbl[j] = '{int'($urandom_range(0, 165)), int'($urandom_range(0, 123)), 4, 1'b0, 1'b0, -1};

        reset = 1'b1; start = 1'b0; origin_x = '0; origin_y = '0;
        repeat (3) @(negedge clk);
        chk("rst_plot", 0, int'(plot), 0);
        chk("rst_busy", 0, int'(busy), 0);
        chk("rst_done", 0, int'(done), 0);
        chk("rst_addr", 0, int'(rom_address), 0);
        chk("rst_x", 0, int'(x), 0);
        chk("rst_y", 0, int'(y), 0);
        chk("rst_colour", 0, int'(colour), 0);
        reset = 1'b0;

        for (int j = 0; j < 10; j++) begin
            run_draw(tbl[j], n);
            if (tbl[j].exp_plots >= 0) chk("plot_count", j, n, tbl[j].exp_plots);
        end

        // Reset in cycle 10 of a draw, then a fresh complete draw.
        @(negedge clk);
        rom_mode = 1; origin_x = 8'd40; origin_y = 7'd40; start = 1'b1;
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            start = 1'b0;
        end
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("mid_rst_plot", 11, int'(plot), 0);
        chk("mid_rst_busy", 11, int'(busy), 0);
        chk("mid_rst_done", 11, int'(done), 0);
        chk("mid_rst_addr", 11, int'(rom_address), 0);
        for (int k = 12; k <= 14; k++) begin
            @(negedge clk);
            chk("post_rst_plot", k, int'(plot), 0);
            chk("post_rst_busy", k, int'(busy), 0);
        end
        vr = '{100, 50, 1, 1'b0, 1'b0, 25};
        run_draw(vr, n);
        chk("post_rst_count", 0, n, 25);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/sprite_plotter.md
Name: sprite_plotter

Overview:
Draws one sprite into the VGA adapter framebuffer, starting at a requested screen origin.
- Scans the sprite positions in raster order and issues addresses to a synchronous sprite ROM.
- Aligns the returned colour with the matching screen coordinate and drives the adapter's plot/x/y/colour write port.
- Sits between the game-logic FSM (start/done handshake) and the VGA adapter.

Parameters:
SPRITE_W, 5, sprite width in pixels
SPRITE_H, 5, sprite height in pixels
ADDR_W, 5, ROM address width; must satisfy 2^ADDR_W >= SPRITE_W*SPRITE_H
COLOUR_W, 3, colour width
SCREEN_W, 160, visible width; x range 0..159
SCREEN_H, 120, visible height; y range 0..119
TRANSPARENT, 0, colour value that is never plotted

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
start  in  1  request a draw; sampled only in IDLE
origin_x  in  8  sprite top-left x; latched when start is accepted
origin_y  in  7  sprite top-left y; latched when start is accepted
busy  out  1  high from the cycle after start is accepted through the done cycle
done  out  1  one-cycle pulse when the draw completes
rom_address  out  ADDR_W  registered ROM read address
rom_data  in  COLOUR_W  ROM q; valid the cycle after rom_address is presented
plot  out  1  framebuffer write enable, registered
x  out  8  write x coordinate, registered
y  out  7  write y coordinate, registered
colour  out  COLOUR_W  write colour, registered

Behaviour:
- Reset values: all outputs are 0; state IDLE; column and row counters 0.
- Reset has priority over every other event, including mid-draw. plot, busy and done read 0 from the next cycle. No partial pixel is emitted after reset.
- States:
  - IDLE -> DRAW when start=1. origin_x and origin_y are latched; col=row=0.
  - DRAW: one address per cycle. rom_address = col + SPRITE_W*row. col increments; at col=SPRITE_W-1, col wraps to 0 and row increments. After address SPRITE_W*SPRITE_H-1 is issued -> FLUSH.
  - FLUSH: 2 cycles; drains the ROM latency and the output register -> DONE.
  - DONE: done=1 for exactly one cycle -> IDLE.
- start is ignored in DRAW, FLUSH and DONE. It is not queued. A start in the DONE cycle is dropped.
- Pipeline: a 1-cycle-delayed copy of (col, row, valid) accompanies each address. When rom_data returns, the output register loads:
  - x = origin_x + col_d
  - y = origin_y + row_d
  - colour = rom_data
  - plot = valid_d AND rom_data != TRANSPARENT AND in-bounds
- Fixed latency: the plot for address i appears 2 cycles after rom_address=i.
- Clipping: sums are computed one bit wider than the coordinate. A pixel is in-bounds only if x_sum < SCREEN_W and y_sum < SCREEN_H. Clipped pixels have plot=0, and no wrap-around to the left or top edge occurs.
- When plot=0, x, y and colour hold their last values; consumers must ignore them.
- Timing for 5x5, with start high in cycle 0:
  - busy is high in cycles 1..28
  - rom_address is 0..24 in cycles 1..25
  - plot candidates appear in cycles 3..27
  - done is high in cycle 28
- Total draw cost is SPRITE_W*SPRITE_H + 3 cycles after acceptance.

Decomposition:
- Shared package sprite_pkg holds:
  - constants SCREEN_W, SCREEN_H, COLOUR_W, TRANSPARENT
  - coordinate widths (X_W=8, Y_W=7)
  - the state encoding (IDLE, DRAW, FLUSH, DONE)
- One sub-module, sprite_scan:
  - col/row raster counter with enable, clear and last flag
  - produces the address and coordinates
  - reusable by other sprite blocks
- The FSM, delay register, clipping and output register stay in sprite_plotter.

Test Plan:
1. ROM model with q=address%8, TRANSPARENT=0; start with origin (10,20) -> 21 plots (addresses 0, 8, 16, 24 skipped). First plot is (11,20) colour 1 in cycle 4; last is (13,24) colour 7 in cycle 26; done=1 only in cycle 28.
2. All-nonzero ROM (q=5), origin (157,118) -> exactly 6 plots: x∈{157,158,159}, y∈{118,119}. No write has x≥160 or y≥120.
3. Start pulsed again in cycles 5 and 28 of a draw -> both ignored: exactly one done, 25 plots total. A start in cycle 29 begins a new draw.
4. Reset asserted in cycle 10 of a draw -> plot=0, busy=0, done=0 and rom_address=0 from cycle 11. A fresh start then yields a complete 25-plot draw.
5. All-TRANSPARENT ROM, origin (0,0) -> zero plots; busy for 28 cycles; done still pulses in cycle 28.
6. Back-to-back draws at (0,0) and then (50,60) with a counting ROM -> the second draw's coordinates are offset correctly. No pixel from the first draw is written with the second draw's origin.
